// File: rtl/fpm_pkg.sv
// Shared types and constants for the single-precision multiplier sequencer.
//   state_e   : controller states
//   opcls_e   : operand class after decode (denormals fold into ZERO)
//   classify  : maps a packed IEEE-754 single to its operand class
package fpm_pkg;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, EXP, MUL, NORM, DONE} state_e;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} opcls_e;

  // Exponent 0 covers both true zero and denormals, which are flushed.
  function automatic opcls_e classify(input logic [31:0] x);
    opcls_e c;
    if (x[30:23] == 8'd0)          c = ZERO;
    else if (x[30:23] != EXP_MAX)  c = NORMAL;
    else if (x[22:0] != 23'd0)     c = NAN;
    else                           c = INF;
    return c;
  endfunction

endpackage

// File: rtl/fpm_seq_ctrl_if.sv
// Operand/result handshake bundle for fpm_seq_ctrl.
//   slave  : the multiplier side (takes operands, produces result)
//   master : the operand source / result consumer side
interface fpm_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        nv;
  logic        busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf, unf, nv, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, unf, nv, busy
  );
endinterface

// File: rtl/fpm_norm_round.sv
// Combinational normalize + round-half-up for the 48-bit mantissa product.
//   p     : raw 24x24 product, leading one at bit 47 or 46
//   e     : unbiased-sum exponent (ea + eb - BIAS), 10-bit signed
//   frac  : rounded 23-bit fraction
//   e_out : exponent after normalize/round carry
//   ovf   : e_out >= 255
//   unf   : e_out <= 0
module fpm_norm_round (
  input  logic        [47:0] p,
  input  logic signed [9:0]  e,
  output logic        [22:0] frac,
  output logic signed [9:0]  e_out,
  output logic               ovf,
  output logic               unf
);

  // pt mirrors P[47:22] after the optional right shift; nothing below
  // bit 22 can influence a round-half-up result, so the rest is dropped.
  logic        [25:0] pt;
  logic signed [9:0]  en;
  logic        [24:0] m25;
  logic               unused_lsb;

  assign unused_lsb = ^p[21:0];

  always_comb begin
    pt    = p[47:22];
    en    = e;
    if (p[47]) begin
      pt = {1'b0, p[47:23]};
      en = e + 10'sd1;
    end
    m25   = pt[25:1] + 25'd1;
    frac  = pt[23:1];
    e_out = en;
    if (pt[0]) begin
      if (m25[24]) begin
        // Rounding carried out to 2.0: mantissa becomes 1.0, bump exponent.
        frac  = m25[23:1];
        e_out = en + 10'sd1;
      end else begin
        frac  = m25[22:0];
      end
    end
    ovf = (e_out >= 10'sd255);
    unf = (e_out <= 10'sd0);
  end

endmodule

// File: rtl/fpm_seq_ctrl.sv
// Sequencing controller for the single-precision FP multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : in_valid/in_ready/a/b operand handshake,
//                out_valid/out_ready/result/ovf/unf/nv result handshake,
//                busy (any state but IDLE)
// Flow: IDLE -> EXP (decode, then special-case decision) -> MUL (24
// shift-add steps) -> NORM -> DONE. Special operands skip MUL/NORM.
module fpm_seq_ctrl
  import fpm_pkg::*;
#(
  parameter int MUL_ITERS = 24,
  parameter int BIAS      = 127
) (
  input  logic           clk,
  input  logic           rst_n,
  fpm_seq_ctrl_if.slave  bus
);

  state_e             state;
  logic               exp_ph;   // 0: decode operands, 1: special-case decision
  logic        [31:0] a_q, b_q;
  logic               sgn;
  logic signed [9:0]  e_q;
  opcls_e             cls_a, cls_b;
  logic        [47:0] mcand;
  logic        [23:0] mplier;
  logic        [47:0] p;
  logic        [4:0]  cnt;

  logic        [31:0] result_q;
  logic               ovf_q, unf_q, nv_q;
  logic               out_valid_q, in_ready_q, busy_q;

  logic        [22:0] nr_frac;
  logic signed [9:0]  nr_e;
  logic               nr_ovf, nr_unf;

  logic               is_nv, is_inf, is_zero;

  fpm_norm_round u_norm (
    .p     (p),
    .e     (e_q),
    .frac  (nr_frac),
    .e_out (nr_e),
    .ovf   (nr_ovf),
    .unf   (nr_unf)
  );

  assign is_nv   = (cls_a == NAN) || (cls_b == NAN) ||
                   (cls_a == INF && cls_b == ZERO) ||
                   (cls_a == ZERO && cls_b == INF);
  assign is_inf  = (cls_a == INF) || (cls_b == INF);
  assign is_zero = (cls_a == ZERO) || (cls_b == ZERO);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.nv        = nv_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      exp_ph      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sgn         <= 1'b0;
      e_q         <= '0;
      cls_a       <= ZERO;
      cls_b       <= ZERO;
      mcand       <= '0;
      mplier      <= '0;
      p           <= '0;
      cnt         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      nv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            exp_ph     <= 1'b0;
            state      <= EXP;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        EXP: begin
          if (!exp_ph) begin
            // Decode is registered so the class decision and the exponent
            // adder both start from flops rather than from the input bus.
            sgn    <= a_q[31] ^ b_q[31];
            e_q    <= 10'({2'b00, a_q[30:23]}) + 10'({2'b00, b_q[30:23]}) - 10'(BIAS);
            cls_a  <= classify(a_q);
            cls_b  <= classify(b_q);
            mcand  <= {24'd0, 1'b1, a_q[22:0]};
            mplier <= {1'b1, b_q[22:0]};
            p      <= '0;
            cnt    <= '0;
            exp_ph <= 1'b1;
          end else begin
            exp_ph <= 1'b0;
            if (is_nv) begin
              result_q    <= QNAN;
              nv_q        <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (is_inf) begin
              result_q    <= {sgn, EXP_MAX, 23'd0};
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else if (is_zero) begin
              result_q    <= {sgn, 31'd0};
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end

        MUL: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MUL_ITERS - 1)) state <= NORM;
        end

        NORM: begin
          e_q <= nr_e;
          if (nr_ovf) begin
            result_q <= {sgn, EXP_MAX, 23'd0};
            ovf_q    <= 1'b1;
          end else if (nr_unf) begin
            result_q <= {sgn, 31'd0};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sgn, nr_e[7:0], nr_frac};
          end
          out_valid_q <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nv_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_seq_ctrl.sv
module tb_fpm_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fpm_seq_ctrl_if bus ();

  fpm_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: products of the operand classes, then an exact integer
  // product rounded half-up at the 24-bit mantissa boundary.
  task automatic ref_mul(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic o, output logic u,
                         output logic v, output int lat);
    int     ex, ey, e;
    bit     s, zx, zy, ix, iy, nx, ny;
    longint prod, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    o = 0; u = 0; v = 0; lat = 2;
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 32'h7FC00000; v = 1;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zx || zy) begin
      r = {s, 31'd0};
    end else begin
      lat  = 27;
      prod = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e    = ex + ey - 127;
      if (prod >= (longint'(1) << 47)) begin
        prod = prod >> 1;
        e++;
      end
      mant = prod >> 23;
      if (((prod >> 22) & 1) == 1) mant++;
      if (mant >= (longint'(1) << 24)) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= 255)      begin r = {s, 8'hFF, 23'd0}; o = 1; end
      else if (e <= 0)   begin r = {s, 31'd0};        u = 1; end
      else               r = {s, 8'(e), 23'(mant)};
    end
  endtask

  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob,
                        input int stall, input bit junk);
    logic [31:0] er;
    logic        eo, eu, ev;
    int          lat, n;
    ref_mul(oa, ob, er, eo, eu, ev, lat);
    bus.in_valid = 1'b1;
    bus.a = oa;
    bus.b = ob;
    tick();
    chk("in_ready_fall", 64'(bus.in_ready), 64'd0);
    chk("busy_rise", 64'(bus.busy), 64'd1);
    if (junk) begin
      bus.a = $urandom;
      bus.b = $urandom;
    end else begin
      bus.in_valid = 1'b0;
    end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (junk) chk("refused_while_busy", 64'(bus.in_ready), 64'd0);
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", 64'(bus.result), 64'(er));
    chk("ovf", 64'(bus.ovf), 64'(eo));
    chk("unf", 64'(bus.unf), 64'(eu));
    chk("nv", 64'(bus.nv), 64'(ev));
    chk("in_ready_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_result", 64'(bus.result), 64'(er));
      chk("stall_flags", 64'({bus.ovf, bus.unf, bus.nv}), 64'({eo, eu, ev}));
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("valid_clear", 64'(bus.out_valid), 64'd0);
    chk("flags_clear", 64'({bus.ovf, bus.unf, bus.nv}), 64'd0);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  ex;
    k  = int'($urandom_range(0, 11));
    ex = 8'($urandom_range(64, 190));
    case (k)
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2:       ex = 8'($urandom_range(1, 254));
      default: ;
    endcase
    if (k == 1 && $urandom_range(0, 1) == 0)
      return {1'($urandom), ex, 23'd0};
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'({bus.ovf, bus.unf, bus.nv}), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    run_op(32'h3FC00000, 32'h40000000, 0, 1'b0);
    chk("dir_1p5x2", 64'(bus.result), 64'h40400000);
    run_op(32'h3F800000, 32'hBF800000, 0, 1'b1);
    chk("dir_1xm1", 64'(bus.result), 64'hBF800000);
    run_op(32'h7F000000, 32'h7F000000, 0, 1'b0);
    run_op(32'h00800000, 32'h00800000, 0, 1'b0);
    run_op(32'h7F800000, 32'h00000000, 0, 1'b0);
    chk("dir_inf_x_zero", 64'(bus.result), 64'h7FC00000);
    run_op(32'hFF800000, 32'h40000000, 0, 1'b0);
    run_op(32'h3FC00000, 32'h3FC00000, 10, 1'b0);

    // Abort mid-multiply: reset lands between clock edges.
    bus.in_valid = 1'b1;
    bus.a = 32'h40400000;
    bus.b = 32'h40400000;
    tick();
    bus.in_valid = 1'b0;
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_flags", 64'({bus.ovf, bus.unf, bus.nv}), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("abort_no_output", 64'(bus.out_valid), 64'd0);
    run_op(32'h3F800000, 32'h40000000, 0, 1'b0);
    chk("post_abort", 64'(bus.result), 64'h40000000);

    for (int i = 0; i < 60; i++)
      run_op(rand_op(), rand_op(), int'($urandom_range(0, 3)), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
